mips_insn_encoder: RTL and testbench
====================================

Name: mips_insn_encoder

Overview:
- Writer-side counterpart of the main decoder: turns instruction requests into 32-bit MIPS instruction words and writes them sequentially into instruction memory.
- Serves as the boot/self-test program loader in front of imem.
- Expands the LI pseudo-op (one or two words) and optionally inserts branch-delay NOPs.
- Tracks the write address, full state and overflow.

Parameters:
- AW, 8, imem word-address width; capacity 2**AW words.
- RESET_ORG, 0, word address loaded into the write counter at reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_kind  in  5  insn_kind_t: RTYPE, LW, LH, LB, LBU, LHU, SW, SH, SB, BEQ, BNE, BLEZ, BGTZ, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, J, JAL, LI
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields
- req_funct  in  6  R-type funct
- req_imm  in  32  immediate (I-type uses [15:0]; LI uses all 32 bits)
- req_target  in  26  J/JAL target
- org_valid  in  1  load write counter
- org_addr  in  AW  new write address
- imem_we  out  1  write strobe
- imem_addr  out  AW  word address
- imem_wdata  out  32  instruction word
- full  out  1  last slot written
- err_ovf  out  1  sticky: request dropped for lack of space
- err_kind  out  1  sticky: undefined req_kind

Behaviour:
- Reset values: imem_we=0, imem_addr=RESET_ORG, imem_wdata=0, full=0, err_ovf=0, err_kind=0, counter=RESET_ORG, state IDLE.
- All outputs are registered.
- Word formats:
  - R-type: {000000, rs, rt, rd, shamt, funct}
  - I-type: {op, rs, rt, imm[15:0]}
  - J-type: {op, target}
  - BLEZ/BGTZ force rt=0; LUI forces rs=0.
- Opcodes are the standard MIPS values.
- FSM states:
  - IDLE: req_ready = ~full & ~org_valid.
  - On accept, the first word appears on imem_wdata with imem_we=1 the next cycle (latency 1).
  - The counter increments after each written word.
  - Back-to-back single-word requests give one write per cycle.
  - SECOND: entered when the accepted request needs a second word. req_ready=0; the second word is written the following cycle, then return to IDLE.
- LI expansion:
  - imm[31:16]==0: one word, ORI rt,$0,imm[15:0].
  - Else imm[15:0]==0: one word, LUI rt,imm[31:16].
  - Else two words: LUI rt,hi, then ORI rt,rt,lo.
- Space check:
  - Free slots = 2**AW - counter.
  - If needed words > free slots, the request is still accepted but produces no write, and err_ovf is set.
- Full:
  - Set when a word is written at address 2**AW-1.
  - The counter does not wrap.
  - req_ready=0 while full.
- org_valid:
  - Has priority over everything.
  - Loads the counter and clears full, err_ovf and err_kind.
  - Aborts SECOND (pending word discarded).
  - No request is accepted that cycle.
- Undefined req_kind: accepted, no write, err_kind set.
- Reset mid-operation: any pending second word is lost and no further write occurs.

Optional Feature:
- Macro: BRANCH_DELAY_NOP_EN.
- Defined: every BEQ, BNE, BLEZ, BGTZ, J or JAL is followed by a 0x00000000 word, written the next cycle through state SECOND. The branch counts as needing 2 slots for the space check.
- Undefined: branches and jumps emit one word; the SECOND state is used only by LI.

Decomposition:
- Package mips_isa_pkg:
  - insn_kind_t enum
  - 6-bit opcode localparams (OP_RTYPE, OP_LW, ... OP_JAL)
  - NOP_WORD constant
  - function words_needed(kind, imm)
- Sub-module insn_word_pack: combinational packer (kind + fields -> word0, word1, two_words, illegal), instantiated once. The top holds the FSM, counter and flags.

Test Plan:
- Reset, then ADDI rs=1 rt=2 imm=0x0005 -> next cycle imem_we=1, addr=0, wdata=0x20220005; addr then advances to 1.
- LI rt=8 imm=0x12345678 -> 0x3C081234 at addr n, 0x35085678 at n+1; req_ready=0 for exactly one cycle.
- LI rt=3 imm=0x000000FF -> single ORI 0x340300FF. LI rt=3 imm=0x00FF0000 -> single LUI 0x3C0300FF.
- AW=2: four ADDIs -> addrs 0..3 written, full=1, req_ready=0. A following LI with 2 words after org_addr=3 -> no write, err_ovf=1. Then org_valid with addr 0 -> full=0, err_ovf=0.
- BEQ rs=1 rt=2 imm=0xFFFF with BRANCH_DELAY_NOP_EN -> 0x1022FFFF then 0x00000000. Without the macro -> a single word.
- Drop reset low the cycle after the LUI of a two-word LI -> no ORI written; imem_we=0; imem_addr=RESET_ORG; all flags 0.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA definitions shared by the instruction encoder and its word packer.
// Contents: request kind enum, 6-bit major opcodes, NOP word, FSM state type,
// and words_needed() which sizes a request for the space check.
// Optional build macro: BRANCH_DELAY_NOP_EN (branches/jumps take two slots).
package mips_isa_pkg;

  typedef enum logic [4:0] {
    RTYPE = 5'd0,  LW    = 5'd1,  LH    = 5'd2,  LB   = 5'd3,
    LBU   = 5'd4,  LHU   = 5'd5,  SW    = 5'd6,  SH   = 5'd7,
    SB    = 5'd8,  BEQ   = 5'd9,  BNE   = 5'd10, BLEZ = 5'd11,
    BGTZ  = 5'd12, ADDI  = 5'd13, ADDIU = 5'd14, ANDI = 5'd15,
    ORI   = 5'd16, XORI  = 5'd17, SLTI  = 5'd18, SLTIU = 5'd19,
    LUI   = 5'd20, J     = 5'd21, JAL   = 5'd22, LI   = 5'd23
  } insn_kind_t;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} enc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Number of imem slots a request occupies. Undefined kinds report 1; they
  // are caught as illegal before the space check matters.
  function automatic logic [1:0] words_needed(input logic [4:0] kind,
                                              input logic [31:0] imm);
    logic [1:0] n;
    n = 2'd1;
    if (kind == LI)
      n = (imm[31:16] != 16'h0 && imm[15:0] != 16'h0) ? 2'd2 : 2'd1;
`ifdef BRANCH_DELAY_NOP_EN
    if (kind == BEQ || kind == BNE || kind == BLEZ || kind == BGTZ ||
        kind == J || kind == JAL)
      n = 2'd2;
`endif
    return n;
  endfunction

endpackage

// File: rtl/insn_word_pack.sv
// Combinational packer: request kind + fields -> one or two MIPS words.
// Ports: kind/rs/rt/rd/shamt/funct/imm/target in; word0, word1, two_words,
// illegal out. Optional build macro: BRANCH_DELAY_NOP_EN (NOP after branches).
module insn_word_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_words,
  output logic        illegal
);

  logic [15:0] hi;
  logic [15:0] lo;
  logic        is_branch;

  assign hi = imm[31:16];
  assign lo = imm[15:0];

  always_comb begin
    word0     = 32'h0;
    word1     = NOP_WORD;
    two_words = 1'b0;
    illegal   = 1'b0;
    is_branch = 1'b0;
    case (kind)
      RTYPE: word0 = {OP_RTYPE, rs, rt, rd, shamt, funct};
      LW:    word0 = {OP_LW,    rs, rt, lo};
      LH:    word0 = {OP_LH,    rs, rt, lo};
      LB:    word0 = {OP_LB,    rs, rt, lo};
      LBU:   word0 = {OP_LBU,   rs, rt, lo};
      LHU:   word0 = {OP_LHU,   rs, rt, lo};
      SW:    word0 = {OP_SW,    rs, rt, lo};
      SH:    word0 = {OP_SH,    rs, rt, lo};
      SB:    word0 = {OP_SB,    rs, rt, lo};
      ADDI:  word0 = {OP_ADDI,  rs, rt, lo};
      ADDIU: word0 = {OP_ADDIU, rs, rt, lo};
      ANDI:  word0 = {OP_ANDI,  rs, rt, lo};
      ORI:   word0 = {OP_ORI,   rs, rt, lo};
      XORI:  word0 = {OP_XORI,  rs, rt, lo};
      SLTI:  word0 = {OP_SLTI,  rs, rt, lo};
      SLTIU: word0 = {OP_SLTIU, rs, rt, lo};
      LUI:   word0 = {OP_LUI,   5'd0, rt, lo};
      BEQ:   begin word0 = {OP_BEQ,  rs, rt,   lo}; is_branch = 1'b1; end
      BNE:   begin word0 = {OP_BNE,  rs, rt,   lo}; is_branch = 1'b1; end
      BLEZ:  begin word0 = {OP_BLEZ, rs, 5'd0, lo}; is_branch = 1'b1; end
      BGTZ:  begin word0 = {OP_BGTZ, rs, 5'd0, lo}; is_branch = 1'b1; end
      J:     begin word0 = {OP_J,   target}; is_branch = 1'b1; end
      JAL:   begin word0 = {OP_JAL, target}; is_branch = 1'b1; end
      LI: begin
        // Pick the shortest sequence that materialises the 32-bit constant.
        if (hi == 16'h0)      word0 = {OP_ORI, 5'd0, rt, lo};
        else if (lo == 16'h0) word0 = {OP_LUI, 5'd0, rt, hi};
        else begin
          word0     = {OP_LUI, 5'd0, rt, hi};
          word1     = {OP_ORI, rt, rt, lo};
          two_words = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
`ifdef BRANCH_DELAY_NOP_EN
    if (is_branch) begin
      word1     = NOP_WORD;
      two_words = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/mips_insn_encoder.sv
// Sequential imem program loader: encodes requests and writes words in order.
// Ports: req_* request handshake/fields, org_* write-origin load, imem_* write
// port (registered), full/err_ovf/err_kind status. Optional macro: BRANCH_DELAY_NOP_EN.
module mips_insn_encoder
  import mips_isa_pkg::*;
#(
  parameter int AW        = 8,
  parameter int RESET_ORG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_kind,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_shamt,
  input  logic [5:0]    req_funct,
  input  logic [31:0]   req_imm,
  input  logic [25:0]   req_target,
  input  logic          org_valid,
  input  logic [AW-1:0] org_addr,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          full,
  output logic          err_ovf,
  output logic          err_kind
);

  enc_state_t  state, state_nxt;
  logic [31:0] word0, word1, pend, wr_word;
  logic        two_words, illegal;
  logic        wr_en, load_pend, set_ovf, set_kind;
  // One extra bit so the counter can sit at 2**AW once the last slot is used.
  logic [AW:0] cnt, free_slots;
  logic [AW:0] need;

  localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

  assign free_slots = CAPACITY - cnt;
  assign need       = (AW+1)'(words_needed(req_kind, req_imm));

  insn_word_pack u_pack (
    .kind      (req_kind),
    .rs        (req_rs),
    .rt        (req_rt),
    .rd        (req_rd),
    .shamt     (req_shamt),
    .funct     (req_funct),
    .imm       (req_imm),
    .target    (req_target),
    .word0     (word0),
    .word1     (word1),
    .two_words (two_words),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    wr_en     = 1'b0;
    wr_word   = 32'h0;
    load_pend = 1'b0;
    set_ovf   = 1'b0;
    set_kind  = 1'b0;
    if (org_valid) begin
      state_nxt = IDLE;  // pending second word is dropped
    end else begin
      case (state)
        IDLE: begin
          req_ready = ~full;
          if (req_valid && !full) begin
            if (illegal)               set_kind = 1'b1;
            else if (need > free_slots) set_ovf = 1'b1;
            else begin
              wr_en   = 1'b1;
              wr_word = word0;
              if (two_words) begin
                load_pend = 1'b1;
                state_nxt = SECOND;
              end
            end
          end
        end
        SECOND: begin
          wr_en     = 1'b1;
          wr_word   = pend;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= (AW+1)'(RESET_ORG);
      pend       <= 32'h0;
      imem_we    <= 1'b0;
      imem_addr  <= AW'(RESET_ORG);
      imem_wdata <= 32'h0;
      full       <= 1'b0;
      err_ovf    <= 1'b0;
      err_kind   <= 1'b0;
    end else if (org_valid) begin
      cnt       <= {1'b0, org_addr};
      imem_we   <= 1'b0;
      imem_addr <= org_addr;
      full      <= 1'b0;
      err_ovf   <= 1'b0;
      err_kind  <= 1'b0;
    end else begin
      imem_we <= wr_en;
      if (wr_en) begin
        imem_addr  <= cnt[AW-1:0];
        imem_wdata <= wr_word;
        cnt        <= cnt + 1'b1;
        if (cnt[AW-1:0] == {AW{1'b1}}) full <= 1'b1;
      end else if (!cnt[AW]) begin
        // Idle address follows the next slot to be written.
        imem_addr <= cnt[AW-1:0];
      end
      if (load_pend) pend     <= word1;
      if (set_ovf)   err_ovf  <= 1'b1;
      if (set_kind)  err_kind <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_insn_encoder.sv
module tb_mips_insn_encoder;
  import mips_isa_pkg::*;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [4:0]    req_kind, req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]    req_funct;
  logic [31:0]   req_imm;
  logic [25:0]   req_target;
  logic          org_valid;
  logic [AW-1:0] org_addr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          full, err_ovf, err_kind;

  int passed = 0;
  int total  = 0;

  mips_insn_encoder #(.AW(AW), .RESET_ORG(0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target),
    .org_valid(org_valid), .org_addr(org_addr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .full(full), .err_ovf(err_ovf), .err_kind(err_kind)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [31:0] im, input logic [25:0] tg);
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_funct = fn; req_imm = im; req_target = tg; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic set_org(input logic [AW-1:0] a);
    org_valid = 1'b1;
    org_addr  = a;
    #1;
    chk("org_blocks_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    org_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_kind = '0; req_rs = '0; req_rt = '0;
    req_rd = '0; req_shamt = '0; req_funct = '0; req_imm = '0; req_target = '0;
    org_valid = 1'b0; org_addr = '0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_we",    {31'b0, imem_we}, 32'd0);
    chk("rst_addr",  {30'b0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_flags", {29'b0, full, err_ovf, err_kind}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    // ADDI $2,$1,5 -> written at 0 one cycle later, address then advances
    send(ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005, 26'd0);
    chk("addi_we",    {31'b0, imem_we}, 32'd1);
    chk("addi_addr",  {30'b0, imem_addr}, 32'd0);
    chk("addi_wdata", imem_wdata, 32'h2022_0005);
    tick();
    chk("idle_we",   {31'b0, imem_we}, 32'd0);
    chk("idle_addr", {30'b0, imem_addr}, 32'd1);

    // Two-word LI: LUI then ORI, ready low for exactly one cycle
    send(LI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678, 26'd0);
    chk("li2_lui",       imem_wdata, 32'h3C08_1234);
    chk("li2_lui_addr",  {30'b0, imem_addr}, 32'd1);
    chk("li2_ready_lo",  {31'b0, req_ready}, 32'd0);
    tick();
    chk("li2_ori_we",    {31'b0, imem_we}, 32'd1);
    chk("li2_ori",       imem_wdata, 32'h3508_5678);
    chk("li2_ori_addr",  {30'b0, imem_addr}, 32'd2);
    chk("li2_ready_hi",  {31'b0, req_ready}, 32'd1);
    tick();

    // Single-word LI forms, back to back, then two ADDIs fill the memory
    set_org(2'd0);
    send(LI, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 32'h0000_00FF, 26'd0);
    chk("li_ori", imem_wdata, 32'h3403_00FF);
    send(LI, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 32'h00FF_0000, 26'd0);
    chk("li_lui",      imem_wdata, 32'h3C03_00FF);
    chk("li_lui_addr", {30'b0, imem_addr}, 32'd1);
    send(RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'd0, 26'd0);
    chk("add_word", imem_wdata, 32'h0022_1820);
    chk("not_full_yet", {31'b0, full}, 32'd0);
    send(ADDI, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 32'h0000_FFFF, 26'd0);
    chk("last_word", imem_wdata, 32'h2085_FFFF);
    chk("last_addr", {30'b0, imem_addr}, 32'd3);
    chk("full_set",  {31'b0, full}, 32'd1);
    chk("full_ready", {31'b0, req_ready}, 32'd0);

    // One free slot, two-word LI -> dropped with overflow
    set_org(2'd3);
    chk("org_clr_full", {31'b0, full}, 32'd0);
    send(LI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678, 26'd0);
    chk("ovf_no_we", {31'b0, imem_we}, 32'd0);
    chk("ovf_set",   {31'b0, err_ovf}, 32'd1);
    tick();
    chk("ovf_no_second", {31'b0, imem_we}, 32'd0);

    // Undefined kind -> no write, err_kind
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 26'd0);
    chk("kind_no_we", {31'b0, imem_we}, 32'd0);
    chk("kind_set",   {31'b0, err_kind}, 32'd1);
    set_org(2'd0);
    chk("org_clr_flags", {29'b0, full, err_ovf, err_kind}, 32'd0);

    // Branch: BEQ, optionally followed by a delay-slot NOP
    send(BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_FFFF, 26'd0);
    chk("beq_word", imem_wdata, 32'h1022_FFFF);
    tick();
`ifdef BRANCH_DELAY_NOP_EN
    chk("beq_nop_we",   {31'b0, imem_we}, 32'd1);
    chk("beq_nop_word", imem_wdata, 32'h0000_0000);
    chk("beq_nop_addr", {30'b0, imem_addr}, 32'd1);
`else
    chk("beq_single_we", {31'b0, imem_we}, 32'd0);
    chk("beq_next_addr", {30'b0, imem_addr}, 32'd1);
`endif
    set_org(2'd0);
    send(BLEZ, 5'd4, 5'd7, 5'd0, 5'd0, 6'd0, 32'h0000_0008, 26'd0);
    chk("blez_rt_zero", imem_wdata, 32'h1880_0008);
    tick();
    set_org(2'd0);
    send(JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 26'h000_0100);
    chk("jal_word", imem_wdata, 32'h0C00_0100);
    tick();

    // Reset between LUI and ORI of a two-word LI
    set_org(2'd0);
    send(LI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678, 26'd0);
    chk("pre_rst_lui", imem_wdata, 32'h3C08_1234);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",    {31'b0, imem_we}, 32'd0);
    chk("mid_rst_addr",  {30'b0, imem_addr}, 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_no_ori", {31'b0, imem_we}, 32'd0);
    chk("post_rst_flags",  {29'b0, full, err_ovf, err_kind}, 32'd0);
    chk("post_rst_ready",  {31'b0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
